regfile_write_ctrl: RTL and testbench

Write-side controller for the 32×64 register file; the write-direction counterpart of the per-bit 32:1 read selection. It accepts write-back requests from the WB stage and decodes the 5-bit destination into one-hot word enables through a 5:32 decoder. It registers the enables and data toward the register file, and keeps a per-register pending-write scoreboard that the hazard unit uses to stall. X31 (XZR) is never written and never reported busy.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/decoder5to32.sv | 17 +
 rtl/regfile_write_ctrl.sv | 107 ++++++++++
 tb/tb_regfile_write_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-side controller.
package regfile_pkg;
    localparam int REG_N  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [1:0]        pend_cnt_t;

    localparam reg_addr_t XZR     = 5'd31;
    localparam pend_cnt_t CNT_MAX = 2'd3;
endpackage

// File: rtl/decoder5to32.sv
// 5:32 one-hot decoder with enable; all-zero output when disabled.
module decoder5to32
    import regfile_pkg::*;
(
    input  reg_addr_t         addr,
    input  logic              en,
    output logic [REG_N-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Write-side controller: registers WB writes toward the register file and keeps
// a per-register pending-write scoreboard for hazard stalls. X31 is never tracked.
module regfile_write_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_N  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  reg_addr_t         issue_addr,
    output logic              issue_ready,
    input  logic              wr_valid,
    input  reg_addr_t         wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [REG_N-1:0]  reg_we,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [REG_N-1:0]  busy,
    output logic              err
);

    localparam int NCNT = REG_N - 1;

    pend_cnt_t        cnt [NCNT];
    pend_cnt_t        issue_cnt;
    logic [REG_N-1:0] inc_vec;
    logic [REG_N-1:0] ret_vec;
    logic             wr_take;
    logic             issue_take;
    logic             underflow;
    logic             inc_unused;

    assign wr_take    = wr_valid && (wr_addr != XZR);
    assign issue_take = issue_valid && issue_ready && (issue_addr != XZR);
    assign inc_unused = inc_vec[REG_N-1];

    always_comb begin
        issue_cnt = '0;
        for (int unsigned i = 0; i < NCNT; i++) begin
            if (issue_addr == reg_addr_t'(i)) begin
                issue_cnt = cnt[i];
            end
        end
    end

    // A same-cycle retire to a full register frees the slot the issue needs.
    assign issue_ready = (issue_addr == XZR)
                      || (issue_cnt != CNT_MAX)
                      || (wr_valid && (wr_addr == issue_addr));

    decoder5to32 u_issue_dec (
        .addr   (issue_addr),
        .en     (issue_take),
        .onehot (inc_vec)
    );

    decoder5to32 u_wr_dec (
        .addr   (wr_addr),
        .en     (wr_take),
        .onehot (ret_vec)
    );

    always_comb begin
        underflow = 1'b0;
        for (int unsigned i = 0; i < NCNT; i++) begin
            if (ret_vec[i] && (cnt[i] == '0)) begin
                underflow = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt[g] <= '0;
            end else begin
                unique case ({inc_vec[g], ret_vec[g]})
                    2'b10:   cnt[g] <= cnt[g] + 2'd1;
                    2'b01:   if (cnt[g] != '0) cnt[g] <= cnt[g] - 2'd1;
                    default: cnt[g] <= cnt[g];
                endcase
            end
        end

        assign busy[g] = (cnt[g] != '0);
    end

    assign busy[REG_N-1] = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_we    <= '0;
            reg_wdata <= '0;
            err       <= 1'b0;
        end else begin
            reg_we <= ret_vec;
            if (wr_take) begin
                reg_wdata <= wr_data;
            end
            if (underflow) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Self-checking bench for regfile_write_ctrl: expected register-file writes are
// queued as stimulus is driven and popped when the registered outputs appear.
module tb_regfile_write_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        issue_ready;
    logic        wr_valid;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [31:0] reg_we;
    logic [63:0] reg_wdata;
    logic [31:0] busy;
    logic        err;

    always #5 clk = ~clk;

    regfile_write_ctrl #(.DATA_W(64), .REG_N(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .reg_we      (reg_we),
        .reg_wdata   (reg_wdata),
        .busy        (busy),
        .err         (err)
    );

    typedef struct packed {
        logic [31:0] we;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] mdata;
    int          checks = 0;
    int          passed = 0;

    task automatic drive(input bit iv, input logic [4:0] ia,
                         input bit wv, input logic [4:0] wa, input logic [63:0] wd);
        issue_valid = iv;
        issue_addr  = ia;
        wr_valid    = wv;
        wr_addr     = wa;
        wr_data     = wd;
    endtask

    // Push the write expected from the current inputs, then advance one edge.
    task automatic tick();
        exp_t e;
        e.we = (wr_valid && wr_addr != 5'd31) ? (32'd1 << wr_addr) : 32'd0;
        if (e.we != 32'd0) mdata = wr_data;
        e.data = mdata;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 5'd0, 0, 5'd0, 64'd0);
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({reg_we, reg_wdata} !== 96'd0)
            $display("FAIL reset_wr: reg_we=%h reg_wdata=%h expected 0 0", reg_we, reg_wdata);
        else passed++;
        checks++;
        if ({busy, err, issue_ready} !== {32'd0, 1'b0, 1'b1})
            $display("FAIL reset_sb: busy=%h err=%b ready=%b expected 0 0 1", busy, err, issue_ready);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        mdata = 64'd0;
        exp_q.delete();
    endtask

    task automatic test_issue_retire();
        exp_t e;
        drive(1, 5'd5, 0, 5'd0, 64'd0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (reg_we !== e.we || reg_wdata !== e.data || busy !== 32'h20)
            $display("FAIL x5_issue: we=%h data=%h busy=%h expected %h %h 00000020", reg_we, reg_wdata, busy, e.we, e.data);
        else passed++;
        drive(0, 5'd0, 0, 5'd0, 64'd0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (reg_we !== e.we || busy !== 32'h20)
            $display("FAIL x5_wait: we=%h busy=%h expected %h 00000020", reg_we, busy, e.we);
        else passed++;
        drive(0, 5'd0, 1, 5'd5, 64'hDEAD_BEEF_0000_0001);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (reg_we !== 32'h20 || reg_wdata !== 64'hDEAD_BEEF_0000_0001 || reg_we !== e.we || busy !== 32'd0)
            $display("FAIL x5_write: we=%h data=%h busy=%h expected 00000020 deadbeef00000001 0", reg_we, reg_wdata, busy);
        else passed++;
        drive(0, 5'd0, 0, 5'd0, 64'd0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (reg_we !== e.we || reg_wdata !== e.data || err !== 1'b0)
            $display("FAIL x5_oneshot: we=%h data=%h err=%b expected %h %h 0", reg_we, reg_wdata, err, e.we, e.data);
        else passed++;
    endtask

    task automatic test_xzr();
        exp_t e;
        drive(1, 5'd31, 1, 5'd31, '1);
        #1;
        checks++;
        if (issue_ready !== 1'b1)
            $display("FAIL xzr_ready: issue_ready=%b expected 1", issue_ready);
        else passed++;
        tick();
        e = exp_q.pop_front();
        checks++;
        if (reg_we !== 32'd0 || reg_wdata !== e.data || busy !== 32'd0 || err !== 1'b0)
            $display("FAIL xzr_write: we=%h data=%h busy=%h err=%b expected 0 %h 0 0", reg_we, reg_wdata, busy, err, e.data);
        else passed++;
    endtask

    task automatic test_saturate();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd2, 0, 5'd0, 64'd0);
            tick();
            e = exp_q.pop_front();
        end
        checks++;
        if (busy !== 32'h4 || reg_we !== e.we)
            $display("FAIL sat_busy: busy=%h we=%h expected 00000004 %h", busy, reg_we, e.we);
        else passed++;
        drive(1, 5'd2, 0, 5'd0, 64'd0);
        #1;
        checks++;
        if (issue_ready !== 1'b0)
            $display("FAIL sat_full: issue_ready=%b expected 0", issue_ready);
        else passed++;
        tick();
        e = exp_q.pop_front();
        drive(1, 5'd2, 1, 5'd2, 64'hA5A5_A5A5_5A5A_5A5A);
        #1;
        checks++;
        if (issue_ready !== 1'b1)
            $display("FAIL sat_bypass: issue_ready=%b expected 1", issue_ready);
        else passed++;
        tick();
        e = exp_q.pop_front();
        checks++;
        if (reg_we !== e.we || reg_wdata !== e.data)
            $display("FAIL sat_write: we=%h data=%h expected %h %h", reg_we, reg_wdata, e.we, e.data);
        else passed++;
        drive(1, 5'd2, 0, 5'd0, 64'd0);
        #1;
        checks++;
        if (issue_ready !== 1'b0)
            $display("FAIL sat_still3: issue_ready=%b expected 0", issue_ready);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            drive(0, 5'd0, 1, 5'd2, 64'(i + 100));
            tick();
            e = exp_q.pop_front();
        end
        checks++;
        if (busy !== 32'd0 || err !== 1'b0 || reg_wdata !== e.data)
            $display("FAIL sat_drain: busy=%h err=%b data=%h expected 0 0 %h", busy, err, reg_wdata, e.data);
        else passed++;
    endtask

    task automatic test_underflow();
        exp_t e;
        drive(0, 5'd0, 1, 5'd7, 64'h7777_0000_7777_0000);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (reg_we !== 32'h80 || reg_we !== e.we || err !== 1'b1 || busy !== 32'd0)
            $display("FAIL under_err: we=%h err=%b busy=%h expected 00000080 1 0", reg_we, err, busy);
        else passed++;
        drive(0, 5'd0, 0, 5'd0, 64'd0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (err !== 1'b1 || reg_we !== e.we)
            $display("FAIL under_sticky: err=%b we=%h expected 1 %h", err, reg_we, e.we);
        else passed++;
        drive(1, 5'd7, 0, 5'd0, 64'd0);
        #1;
        checks++;
        if (issue_ready !== 1'b1)
            $display("FAIL under_ready: issue_ready=%b expected 1", issue_ready);
        else passed++;
        tick();
        e = exp_q.pop_front();
        drive(0, 5'd0, 1, 5'd7, 64'h1);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (busy !== 32'd0 || reg_wdata !== e.data)
            $display("FAIL under_cnt0: busy=%h data=%h expected 0 %h", busy, reg_wdata, e.data);
        else passed++;
    endtask

    task automatic test_same_cycle();
        exp_t e;
        drive(1, 5'd9, 0, 5'd0, 64'd0);
        tick();
        e = exp_q.pop_front();
        drive(1, 5'd9, 1, 5'd9, 64'h9999_8888_7777_6666);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (reg_we !== 32'h200 || reg_wdata !== e.data || busy !== 32'h200)
            $display("FAIL same_cyc: we=%h data=%h busy=%h expected 00000200 %h 00000200", reg_we, reg_wdata, busy, e.data);
        else passed++;
        drive(0, 5'd0, 1, 5'd9, 64'h2);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (busy !== 32'd0 || reg_we !== e.we)
            $display("FAIL same_drain: busy=%h we=%h expected 0 %h", busy, reg_we, e.we);
        else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        drive(0, 5'd0, 1, 5'd3, 64'h0123_4567_89AB_CDEF);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (reg_we !== e.we || reg_wdata !== e.data)
            $display("FAIL b2b_first: we=%h data=%h expected %h %h", reg_we, reg_wdata, e.we, e.data);
        else passed++;
        drive(0, 5'd0, 1, 5'd3, 64'hFEDC_BA98_7654_3210);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (reg_we !== e.we || reg_wdata !== e.data)
            $display("FAIL b2b_second: we=%h data=%h expected %h %h", reg_we, reg_wdata, e.we, e.data);
        else passed++;
        drive(0, 5'd0, 0, 5'd0, 64'd0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (reg_we !== e.we || reg_wdata !== e.data)
            $display("FAIL b2b_idle: we=%h data=%h expected %h %h", reg_we, reg_wdata, e.we, e.data);
        else passed++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive(1, 5'd4, 0, 5'd0, 64'd0);
            tick();
            e = exp_q.pop_front();
        end
        checks++;
        if (busy !== 32'h10)
            $display("FAIL mid_pre: busy=%h expected 00000010", busy);
        else passed++;
        drive(0, 5'd0, 1, 5'd4, 64'hCAFE_F00D_CAFE_F00D);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({reg_we, reg_wdata, busy, err, issue_ready} !== {32'd0, 64'd0, 32'd0, 1'b0, 1'b1})
            $display("FAIL mid_async: we=%h data=%h busy=%h err=%b ready=%b expected 0 0 0 0 1",
                     reg_we, reg_wdata, busy, err, issue_ready);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (reg_we !== 32'd0 || reg_wdata !== 64'd0)
            $display("FAIL mid_drop: we=%h data=%h expected 0 0", reg_we, reg_wdata);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        drive(0, 5'd0, 0, 5'd0, 64'd0);
        mdata = 64'd0;
        exp_q.delete();
    endtask

    initial begin
        mdata = 64'd0;
        test_reset();
        test_issue_retire();
        test_xzr();
        test_saturate();
        test_underflow();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
